// File: rtl/rom_dl_sequencer_if.sv
// ---------------------------------------------------------------------------
// rom_dl_sequencer_if
// Bundles the data_io download bus and the core ROM write port that the ROM
// download sequencer sits between. All signals are in the clk_sys domain.
//
//   ioctl_downl  data_io download active
//   ioctl_index  data_io image index (8)
//   ioctl_wr     data_io byte strobe, one cycle per byte
//   ioctl_addr   data_io byte address (25)
//   ioctl_dout   data_io byte (8)
//   dl_addr      core ROM write address (ADDR_W)
//   dl_data      core ROM write data (8)
//   dl_wr        core ROM write strobe
//
// master: the environment side (data_io drives, core ROM receives).
// slave : the sequencer side (takes the download, drives the ROM port).
// ---------------------------------------------------------------------------
interface rom_dl_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic              ioctl_downl;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic [ADDR_W-1:0] dl_addr;
  logic [7:0]        dl_data;
  logic              dl_wr;

  modport master (
    output ioctl_downl, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  dl_addr, dl_data, dl_wr
  );

  modport slave (
    input  ioctl_downl, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output dl_addr, dl_data, dl_wr
  );
endinterface

// File: rtl/rom_dl_sequencer.sv
// ---------------------------------------------------------------------------
// rom_dl_sequencer
// Moves a ROM image from data_io into the game core's ROM write port and owns
// the core reset. The core is held in reset from power-up, during a download
// and for HOLD_CYCLES afterwards; a user reset request re-enters the hold.
// The downloaded length is checked against EXP_LEN and an image that is short,
// long or has out-of-range bytes never releases the core.
//
// Ports:
//   clk_sys     system clock, rising edge
//   reset_n     asynchronous active-low reset
//   bus         rom_dl_sequencer_if.slave (ioctl_* in, dl_* out)
//   user_reset  OSD/button reset request, level
//   core_reset  active-high reset to the game core (registered)
//   loaded      a valid image is present (registered)
//   len_err     last download had a wrong length or out-of-range bytes
//   byte_count  bytes accepted in the current/last download, saturating
// ---------------------------------------------------------------------------
module rom_dl_sequencer #(
  parameter int          ADDR_W      = 16,
  parameter logic [16:0] EXP_LEN     = 17'h0C000,
  parameter logic [7:0]  DL_INDEX    = 8'h00,
  parameter int          HOLD_CYCLES = 1024
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  rom_dl_sequencer_if.slave       bus,
  input  logic                    user_reset,
  output logic                    core_reset,
  output logic                    loaded,
  output logic                    len_err,
  output logic [16:0]             byte_count
);

  localparam int              HC_W       = $clog2(HOLD_CYCLES + 1);
  localparam logic [HC_W-1:0] HOLD_RLD   = HC_W'(HOLD_CYCLES - 1);
  localparam logic [HC_W-1:0] HC_ZERO    = {HC_W{1'b0}};
  localparam logic [HC_W-1:0] HC_ONE     = HC_W'(1);
  localparam logic [16:0]     BC_MAX     = 17'h1FFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_HOLD = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_dl_sel_q;
  logic              r_core_reset;
  logic              r_loaded;
  logic              r_len_err;
  logic              r_check_pend;
  logic [16:0]       r_byte_count;
  logic [HC_W-1:0]   r_hold_cnt;
  logic              r_dl_wr;
  logic [ADDR_W-1:0] r_dl_addr;
  logic [7:0]        r_dl_data;

  logic w_idx_match;
  logic w_dl_sel;
  logic w_start;
  logic w_fall;
  logic w_in_range;
  logic w_wr_hit;
  logic w_wr_ok;
  logic w_wr_bad;
  logic w_len_final;
  logic w_loaded_eff;
  logic w_hold_reload;
  logic w_hold_dec;

  assign w_idx_match = (bus.ioctl_index == DL_INDEX);
  assign w_dl_sel    = bus.ioctl_downl & w_idx_match;
  assign w_start     = w_dl_sel & ~r_dl_sel_q;
  assign w_fall      = ~w_dl_sel & r_dl_sel_q;
  assign w_in_range  = ((bus.ioctl_addr >> ADDR_W) == 25'd0);

  // A strobe is taken while loading (or in the start cycle itself). In the
  // cycle dl_sel drops, r_dl_sel_q keeps the window open so a last byte that
  // arrives together with the falling download flag still lands.
  assign w_wr_hit = bus.ioctl_wr & w_idx_match
                  & ((r_state == S_LOAD) | w_start)
                  & (w_dl_sel | r_dl_sel_q);
  assign w_wr_ok  = w_wr_hit & w_in_range;
  assign w_wr_bad = w_wr_hit & ~w_in_range;

  // The length check runs in the first HOLD cycle, after the final byte has
  // been counted; the release decision uses that fresh result.
  assign w_len_final  = r_len_err | (r_byte_count != EXP_LEN);
  assign w_loaded_eff = r_check_pend ? ~w_len_final : r_loaded;

  // Next-state and hold-counter control
  always_comb begin
    w_state_next  = r_state;
    w_hold_reload = 1'b0;
    w_hold_dec    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_next = S_IDLE;
      end
      S_LOAD: begin
        if (w_fall) begin
          w_state_next  = S_HOLD;
          w_hold_reload = 1'b1;
        end else begin
          w_state_next = S_LOAD;
        end
      end
      S_HOLD: begin
        if (user_reset) begin
          w_state_next  = S_HOLD;
          w_hold_reload = 1'b1;
        end else if (r_hold_cnt == HC_ZERO) begin
          // A bad image parks here for good.
          if (w_loaded_eff) begin
            w_state_next = S_RUN;
          end else begin
            w_state_next = S_HOLD;
          end
        end else begin
          w_state_next = S_HOLD;
          w_hold_dec   = 1'b1;
        end
      end
      S_RUN: begin
        if (user_reset) begin
          w_state_next  = S_HOLD;
          w_hold_reload = 1'b1;
        end else begin
          w_state_next = S_RUN;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    // A new matching download overrides everything, from any state.
    if (w_start) begin
      w_state_next  = S_LOAD;
      w_hold_reload = 1'b0;
      w_hold_dec    = 1'b0;
    end else begin
      w_state_next = w_state_next;
    end
  end

  // State register, download-select history and core reset output
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_dl_sel_q   <= 1'b0;
      r_core_reset <= 1'b1;
      r_check_pend <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_dl_sel_q   <= w_dl_sel;
      r_core_reset <= (w_state_next != S_RUN);
      r_check_pend <= (r_state == S_LOAD) & w_fall;
    end
  end

  // Hold counter: reloaded on entry to HOLD and on user reset, then counts down
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_hold_cnt <= HC_ZERO;
    end else if (w_hold_reload) begin
      r_hold_cnt <= HOLD_RLD;
    end else if (w_hold_dec) begin
      r_hold_cnt <= r_hold_cnt - HC_ONE;
    end else begin
      r_hold_cnt <= r_hold_cnt;
    end
  end

  // Core ROM write port: fixed one-cycle registered copy of an accepted byte
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_dl_wr   <= 1'b0;
      r_dl_addr <= {ADDR_W{1'b0}};
      r_dl_data <= 8'h00;
    end else begin
      r_dl_wr <= w_wr_ok;
      if (w_wr_ok) begin
        r_dl_addr <= bus.ioctl_addr[ADDR_W-1:0];
        r_dl_data <= bus.ioctl_dout;
      end else begin
        r_dl_addr <= r_dl_addr;
        r_dl_data <= r_dl_data;
      end
    end
  end

  // Accepted-byte counter, restarted (with any start-cycle byte) on a new download
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_byte_count <= 17'h00000;
    end else if (w_start) begin
      r_byte_count <= w_wr_ok ? 17'h00001 : 17'h00000;
    end else if (w_wr_ok && (r_byte_count != BC_MAX)) begin
      r_byte_count <= r_byte_count + 17'h00001;
    end else begin
      r_byte_count <= r_byte_count;
    end
  end

  // Image status: error flag and loaded flag
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_len_err <= 1'b0;
      r_loaded  <= 1'b0;
    end else if (w_start) begin
      r_len_err <= w_wr_bad;
      r_loaded  <= 1'b0;
    end else if (r_check_pend) begin
      r_len_err <= w_len_final;
      r_loaded  <= ~w_len_final;
    end else if (w_wr_bad) begin
      r_len_err <= 1'b1;
      r_loaded  <= r_loaded;
    end else begin
      r_len_err <= r_len_err;
      r_loaded  <= r_loaded;
    end
  end

  assign bus.dl_wr   = r_dl_wr;
  assign bus.dl_addr = r_dl_addr;
  assign bus.dl_data = r_dl_data;
  assign core_reset  = r_core_reset;
  assign loaded      = r_loaded;
  assign len_err     = r_len_err;
  assign byte_count  = r_byte_count;

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rom_dl_sequencer
// Directed bench for rom_dl_sequencer with a scoreboard on the ROM write port:
// every byte driven with the matching index and an in-range address pushes its
// expected {addr, data, cycle} into a queue; a monitor pops and compares each
// time dl_wr is seen. Status outputs are compared against hand-derived values.
// Small parameters keep the run short: EXP_LEN=0x180, HOLD_CYCLES=16.
// ---------------------------------------------------------------------------
module tb_rom_dl_sequencer;

  localparam int          ADDR_W = 16;
  localparam logic [16:0] EXP    = 17'h00180;
  localparam int          H      = 16;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    int          c;
  } exp_t;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        user_reset;
  logic        core_reset;
  logic        loaded;
  logic        len_err;
  logic [16:0] byte_count;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  logic [7:0] cur_idx;
  exp_t q[$];

  rom_dl_sequencer_if #(.ADDR_W(ADDR_W)) dl_bus ();

  rom_dl_sequencer #(
    .ADDR_W     (ADDR_W),
    .EXP_LEN    (EXP),
    .DL_INDEX   (8'h00),
    .HOLD_CYCLES(H)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .bus       (dl_bus),
    .user_reset(user_reset),
    .core_reset(core_reset),
    .loaded    (loaded),
    .len_err   (len_err),
    .byte_count(byte_count)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Scoreboard monitor on the ROM write port
  always @(negedge clk_sys) begin
    if (reset_n === 1'b1 && dl_bus.dl_wr !== 1'b0) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL dl_wr_unexpected: got dl_wr=%b addr=%h at cycle %0d, required no write",
                 dl_bus.dl_wr, dl_bus.dl_addr, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (dl_bus.dl_addr !== e.a || dl_bus.dl_data !== e.d || cyc != e.c) begin
          n_bad++;
          $display("FAIL dl_wr_beat: got addr=%h data=%h cycle=%0d, required addr=%h data=%h cycle=%0d",
                   dl_bus.dl_addr, dl_bus.dl_data, cyc, e.a, e.d, e.c);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic start_dl(input logic [7:0] idx);
    cur_idx             = idx;
    dl_bus.ioctl_index  = idx;
    dl_bus.ioctl_downl  = 1'b1;
    tick();
  endtask

  // One byte; data is the low address byte. 'fall' drops downl in the same cycle.
  task automatic wr_byte(input int addr, input bit fall);
    logic [31:0] a;
    a                  = addr;
    dl_bus.ioctl_addr  = a[24:0];
    dl_bus.ioctl_dout  = a[7:0];
    dl_bus.ioctl_wr    = 1'b1;
    if (fall) dl_bus.ioctl_downl = 1'b0;
    if (cur_idx == 8'h00 && a < 32'h00010000) begin
      q.push_back('{a: a[15:0], d: a[7:0], c: cyc + 1});
    end
    tick();
    dl_bus.ioctl_wr = 1'b0;
  endtask

  task automatic end_dl();
    dl_bus.ioctl_wr    = 1'b0;
    dl_bus.ioctl_downl = 1'b0;
  endtask

  initial begin
    reset_n            = 1'b0;
    user_reset         = 1'b0;
    dl_bus.ioctl_downl = 1'b0;
    dl_bus.ioctl_index = 8'h00;
    dl_bus.ioctl_wr    = 1'b0;
    dl_bus.ioctl_addr  = 25'd0;
    dl_bus.ioctl_dout  = 8'h00;
    cur_idx            = 8'h00;
    repeat (3) tick();

    // Reset values
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_loaded",     32'(loaded),     32'd0);
    chk("rst_len_err",    32'(len_err),    32'd0);
    chk("rst_byte_count", 32'(byte_count), 32'd0);
    chk("rst_dl_wr",      32'(dl_bus.dl_wr),   32'd0);
    chk("rst_dl_addr",    32'(dl_bus.dl_addr), 32'd0);
    chk("rst_dl_data",    32'(dl_bus.dl_data), 32'd0);

    // Idle after reset: core stays in reset, no writes (monitor flags any)
    reset_n = 1'b1;
    repeat (2000) tick();
    chk("idle_core_reset", 32'(core_reset), 32'd1);
    chk("idle_loaded",     32'(loaded),     32'd0);

    // Full download, last byte together with downl falling
    start_dl(8'h00);
    for (int i = 0; i < 32'(EXP) - 1; i++) wr_byte(i, 1'b0);
    wr_byte(32'(EXP) - 1, 1'b1);
    // one edge has passed since downl fell; release is H+1 edges after it
    repeat (H - 1) tick();
    chk("full_core_reset_held", 32'(core_reset), 32'd1);
    chk("full_byte_count", 32'(byte_count), 32'h180);
    chk("full_len_err",    32'(len_err),    32'd0);
    chk("full_loaded",     32'(loaded),     32'd1);
    tick();
    chk("full_core_reset_release", 32'(core_reset), 32'd0);
    chk("full_sb_drained", 32'(q.size()), 32'd0);

    // User reset pulse in RUN
    repeat (3) tick();
    user_reset = 1'b1;
    tick();
    user_reset = 1'b0;
    chk("ureset_core_reset_rise", 32'(core_reset), 32'd1);
    repeat (H - 1) tick();
    chk("ureset_core_reset_held", 32'(core_reset), 32'd1);
    tick();
    chk("ureset_core_reset_release", 32'(core_reset), 32'd0);
    chk("ureset_loaded", 32'(loaded), 32'd1);

    // Foreign-index download while running: no effect
    start_dl(8'h01);
    for (int i = 0; i < 16; i++) wr_byte(i, 1'b0);
    end_dl();
    repeat (H + 4) tick();
    chk("idx1_core_reset", 32'(core_reset), 32'd0);
    chk("idx1_loaded",     32'(loaded),     32'd1);
    chk("idx1_byte_count", 32'(byte_count), 32'h180);

    // Short re-download from RUN
    start_dl(8'h00);
    chk("short_core_reset_enter", 32'(core_reset), 32'd1);
    chk("short_loaded_cleared",   32'(loaded),     32'd0);
    for (int i = 0; i < 32'h80; i++) wr_byte(i, 1'b0);
    end_dl();
    repeat (3 * H) tick();
    chk("short_byte_count", 32'(byte_count), 32'h80);
    chk("short_len_err",    32'(len_err),    32'd1);
    chk("short_loaded",     32'(loaded),     32'd0);
    chk("short_core_reset", 32'(core_reset), 32'd1);

    // Correct length plus one out-of-range byte
    start_dl(8'h00);
    for (int i = 0; i < 32'(EXP); i++) wr_byte(i, 1'b0);
    wr_byte(32'h10000, 1'b0);
    end_dl();
    repeat (3 * H) tick();
    chk("oor_byte_count", 32'(byte_count), 32'h180);
    chk("oor_len_err",    32'(len_err),    32'd1);
    chk("oor_loaded",     32'(loaded),     32'd0);
    chk("oor_core_reset", 32'(core_reset), 32'd1);

    // Reset mid-download at byte 0x100
    start_dl(8'h00);
    for (int i = 0; i < 32'h100; i++) wr_byte(i, 1'b0);
    tick();
    reset_n            = 1'b0;
    dl_bus.ioctl_downl = 1'b0;
    #1;
    chk("midrst_core_reset", 32'(core_reset), 32'd1);
    chk("midrst_byte_count", 32'(byte_count), 32'd0);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (2 * H) tick();
    chk("midrst_idle_loaded",     32'(loaded),     32'd0);
    chk("midrst_idle_core_reset", 32'(core_reset), 32'd1);

    // Full re-download after the aborted one
    start_dl(8'h00);
    for (int i = 0; i < 32'(EXP); i++) wr_byte(i, 1'b0);
    end_dl();
    repeat (H + 4) tick();
    chk("redl_byte_count", 32'(byte_count), 32'h180);
    chk("redl_len_err",    32'(len_err),    32'd0);
    chk("redl_loaded",     32'(loaded),     32'd1);
    chk("redl_core_reset", 32'(core_reset), 32'd0);
    chk("end_sb_drained",  32'(q.size()),   32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
